// File: rtl/arm_cpu_pkg.sv
// Shared CPU types and constants for the ARMv8 integer datapath.
// Holds register-file geometry, the XZR register number and word/regnum types.
// Consumers import this with a wildcard import.
package arm_cpu_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  // Register number 31 reads as zero and swallows writes (XZR).
  localparam logic [4:0] XZR_ADDR = 5'd31;

  typedef logic [63:0] word_t;
  typedef logic [4:0]  regnum_t;

endpackage

// File: rtl/decoder_5to32.sv
// Enable-gated 5:32 one-hot decoder for register-file write strobes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module decoder_5to32
  import arm_cpu_pkg::*;
(
  input  logic        i_en,
  input  regnum_t     i_addr,
  output logic [31:0] o_sel
);

  // At most one select bit high, and only while the enable is asserted.
  always_comb begin
    o_sel = '0;
    if (i_en) begin
      o_sel[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/register64.sv
// One 64-bit register-file entry with a load enable and async clear.
// Latency: loads on the rising clock edge, output visible just after it.
// Backpressure: none; holds its value whenever the enable is low.
module register64
  import arm_cpu_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_en,
  input  word_t i_d,
  output word_t o_q
);

  word_t r_q;

  // Reset dominates any same-cycle load so a write racing reset is lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_32x64.sv
// ARMv8 32x64 integer register file: 2 combinational read ports, 1 write port, XZR at 31.
// Latency: reads zero cycles; a write is visible just after its clock edge.
// Backpressure: none. Optional macro REGFILE_BYPASS_EN forwards wr_data to matching reads.
module regfile_32x64 #(
  parameter int DATA_WIDTH = arm_cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = arm_cpu_pkg::ADDR_WIDTH,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2
);

  import arm_cpu_pkg::*;

  localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

  // Per-entry write strobes and stored contents; the XZR slot is a constant zero.
  logic [NUM_ENTRIES-1:0] w_wr_sel;
  logic [DATA_WIDTH-1:0]  w_q [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  w_rd1_stored;
  logic [DATA_WIDTH-1:0]  w_rd2_stored;
  logic                   w_unused_sel;

  decoder_5to32 u_wr_dec (
    .i_en   (wr_en),
    .i_addr (wr_addr),
    .o_sel  (w_wr_sel)
  );

  // XZR has no storage, so its strobe goes nowhere.
  assign w_unused_sel = w_wr_sel[ZERO_REG];

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    if (gi == ZERO_REG) begin : g_zero
      assign w_q[gi] = '0;
    end else begin : g_reg
      register64 u_reg (
        .i_clk (clk),
        .i_rst (reset),
        .i_en  (w_wr_sel[gi]),
        .i_d   (wr_data),
        .o_q   (w_q[gi])
      );
    end
  end

  // Read muxes; address ZERO_REG selects the tied-off zero slot.
  assign w_rd1_stored = w_q[rd_addr1];
  assign w_rd2_stored = w_q[rd_addr2];

`ifdef REGFILE_BYPASS_EN
  // Forward only live, non-XZR writes; reset must still force reads to zero.
  logic w_byp_ok;
  assign w_byp_ok = wr_en & ~reset & (wr_addr != ADDR_WIDTH'(ZERO_REG));
  assign rd_data1 = (w_byp_ok && (wr_addr == rd_addr1)) ? wr_data : w_rd1_stored;
  assign rd_data2 = (w_byp_ok && (wr_addr == rd_addr2)) ? wr_data : w_rd2_stored;
`else
  assign rd_data1 = w_rd1_stored;
  assign rd_data2 = w_rd2_stored;
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64 (default and REGFILE_BYPASS_EN builds).
// Drives on the falling edge, samples #1 after changes, all checks through chk().
// Expected values are hand-derived constants.
module tb_regfile_32x64;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [63:0] rd_data1;
  logic [63:0] rd_data2;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_32x64 dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An unknown write address under an active strobe is illegal.
  always @(posedge clk) begin
    if (wr_en) begin
      assert (!$isunknown(wr_addr)) else $error("FAIL wr_addr_x: wr_addr unknown with wr_en=1");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic rd_both(input logic [4:0] a, input logic [63:0] exp, input string tag);
    rd_addr1 = a;
    rd_addr2 = a;
    #1;
    chk({tag, "_p1"}, rd_data1, exp);
    chk({tag, "_p2"}, rd_data2, exp);
  endtask

  logic [63:0] exp_same;

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;

    // 1: reset held with arbitrary addresses, then released
    #2;
    rd_addr1 = 5'($urandom_range(0, 31));
    rd_addr2 = 5'($urandom_range(0, 31));
    #1;
    chk("rst_held_p1", rd_data1, 64'h0);
    chk("rst_held_p2", rd_data2, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) rd_both(5'(i), 64'h0, "rst_rel");

    // 2: write X_i = 0x1000+i, read back on both ports with differing addresses
    for (int i = 0; i < 31; i++) wr(5'(i), 64'h1000 + 64'(i));
    for (int i = 0; i < 31; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(30 - i);
      #1;
      chk("wr_all_p1", rd_data1, 64'h1000 + 64'(i));
      chk("wr_all_p2", rd_data2, 64'h1000 + 64'(30 - i));
    end
    rd_both(5'd31, 64'h0, "x31_read");

    // 3: XZR write is discarded, even while it is in flight
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 5'd31;
    wr_data  = 64'hDEAD_BEEF;
    rd_addr1 = 5'd31;
    rd_addr2 = 5'd31;
    #1;
    chk("xzr_inflight_p1", rd_data1, 64'h0);
    chk("xzr_inflight_p2", rd_data2, 64'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_both(5'd31, 64'h0, "xzr_after");
    for (int i = 0; i < 31; i++) rd_both(5'(i), 64'h1000 + 64'(i), "xzr_others");

    // 4: enable gating
    @(negedge clk);
    wr_en   = 1'b0;
    wr_addr = 5'd5;
    wr_data = 64'hFFFF;
    @(posedge clk);
    #1;
    rd_both(5'd5, 64'h1005, "en_gate");

    // 5: same-cycle write and read of X7; port 2 also checked on a non-matching address
`ifdef REGFILE_BYPASS_EN
    exp_same = 64'hABCD;
`else
    exp_same = 64'h1007;
`endif
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 64'hABCD;
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd7;
    #1;
    chk("same_pre_p1", rd_data1, exp_same);
    chk("same_pre_p2", rd_data2, exp_same);
    rd_addr2 = 5'd8;
    #1;
    chk("same_pre_indep_p1", rd_data1, exp_same);
    chk("same_pre_indep_p2", rd_data2, 64'h1008);
    rd_addr2 = 5'd7;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    chk("same_post_p1", rd_data1, 64'hABCD);
    chk("same_post_p2", rd_data2, 64'hABCD);

    // 6: async reset between edges with a concurrent write to X3
    wr(5'd3, 64'h55);
    rd_both(5'd3, 64'h55, "x3_set");
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 64'h77;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd5;
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_x3", rd_data1, 64'h0);
    chk("rst_mid_x5", rd_data2, 64'h0);
    @(posedge clk);
    #1;
    chk("rst_edge_x3", rd_data1, 64'h0);
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_rel_x3_p1", rd_data1, 64'h0);
    chk("rst_rel_x5_p2", rd_data2, 64'h0);
    @(posedge clk);
    #1;
    rd_both(5'd3, 64'h0, "rst_lost_wr");

    // post-reset write still works
    wr(5'd30, 64'h1234_5678_9ABC_DEF0);
    rd_both(5'd30, 64'h1234_5678_9ABC_DEF0, "post_rst_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
